// File: rtl/tprescaler_cfg_ctrl.sv
// Timer prescaler configuration controller.
// Grants prescale-value updates round-robin, holds the granted value in a shadow register
// and applies it only at a safe boundary (disabled, cleared or period wrap). Also runs the
// prescaler counter and produces the registered prescaled tick.
module tprescaler_cfg_ctrl #(
  parameter int unsigned PRESCALER_WIDTH = 8,
  parameter int unsigned NUM_REQ         = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               clear_i,
  input  logic                               ref_tick_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*PRESCALER_WIDTH-1:0] req_value_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [PRESCALER_WIDTH-1:0]         cur_value_o,
  output logic                               pending_o,
  output logic [PRESCALER_WIDTH-1:0]         count_o,
  output logic                               tick_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e                     state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] cur_q, cur_d;
  logic [PRESCALER_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALER_WIDTH-1:0] shadow_q, shadow_d;
  logic                       tick_q, tick_d;
  logic [IdxW-1:0]            rr_q, rr_d;

  logic [NUM_REQ-1:0]         grant;
  logic [PRESCALER_WIDTH-1:0] grant_value;
  logic [IdxW-1:0]            next_ptr;
  logic                       found;
  logic                       qual, wrap, apply, transfer;

  // Round-robin grant: first valid requester at or after rr_q; only offered while idle.
  // Depends on valid, state and pointer only, never on the requested value.
  always_comb begin
    grant       = '0;
    grant_value = '0;
    next_ptr    = '0;
    found       = 1'b0;
    if (state_q == StIdle) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
          if (!found && req_valid_i[r] && (r == (32'(rr_q) + i) % NUM_REQ)) begin
            found       = 1'b1;
            grant[r]    = 1'b1;
            grant_value = req_value_i[r*PRESCALER_WIDTH +: PRESCALER_WIDTH];
            next_ptr    = IdxW'((r + 1) % NUM_REQ);
          end
        end
      end
    end
  end

  assign qual     = enable_i & ref_tick_i;
  assign wrap     = qual & (cnt_q == cur_q);
  assign apply    = (state_q == StPending) & (~enable_i | clear_i | wrap);
  assign transfer = |grant;

  // Next-state: apply beats clear beats counting; a wrap still ticks even when it applies.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    rr_d     = rr_q;
    tick_d   = wrap & ~clear_i;

    if (apply) begin
      cur_d   = shadow_q;
      cnt_d   = '0;
      state_d = StIdle;
    end else if (clear_i || wrap) begin
      cnt_d = '0;
    end else if (qual) begin
      cnt_d = cnt_q + PRESCALER_WIDTH'(1);
    end

    // Transfer only happens in idle and apply only in pending, so they never collide.
    if (transfer) begin
      shadow_d = grant_value;
      rr_d     = next_ptr;
      state_d  = StPending;
    end
  end

  // State registers with synchronous active-high reset; a reset drops any pending update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      tick_q   <= 1'b0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      rr_q     <= rr_d;
    end
  end

  assign req_ready_o = grant;
  assign cur_value_o = cur_q;
  assign pending_o   = (state_q == StPending);
  assign count_o     = cnt_q;
  assign tick_o      = tick_q;

endmodule

// File: tb/tb_tprescaler_cfg_ctrl.sv
// Self-checking bench for tprescaler_cfg_ctrl with a per-cycle scoreboard plus scenario checks.
module tb_tprescaler_cfg_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, clear_i, ref_tick_i;
  logic [1:0]  req_valid_i;
  logic [15:0] req_value_i;
  logic [1:0]  req_ready_o;
  logic [7:0]  cur_value_o, count_o;
  logic        pending_o, tick_o;

  always #5 clk_i = ~clk_i;

  tprescaler_cfg_ctrl #(
    .PRESCALER_WIDTH(8),
    .NUM_REQ        (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .clear_i    (clear_i),
    .ref_tick_i (ref_tick_i),
    .req_valid_i(req_valid_i),
    .req_value_i(req_value_i),
    .req_ready_o(req_ready_o),
    .cur_value_o(cur_value_o),
    .pending_o  (pending_o),
    .count_o    (count_o),
    .tick_o     (tick_o)
  );

  int compared   = 0;
  int mismatched = 0;

  // Scoreboard entries: {cur, count, tick, pending, ready-before-edge}
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  logic [19:0] e, o;
  logic [1:0]  last_rdy;

  // Reference model state
  logic [7:0] m_cur = 8'd0, m_cnt = 8'd0, m_shadow = 8'd0;
  logic       m_tick = 1'b0, m_pend = 1'b0, m_rr = 1'b0;

  // Drives one cycle, pushes the expected result, captures the observed result.
  task automatic drive(input logic rst, input logic en, input logic clr, input logic rt,
                       input logic [1:0] vld, input logic [7:0] v0, input logic [7:0] v1);
    logic [1:0] g;
    logic [7:0] n_cur, n_cnt, n_sh;
    logic       n_tick, n_pend, n_rr, q, w, ap;
    rst_i       = rst;
    enable_i    = en;
    clear_i     = clr;
    ref_tick_i  = rt;
    req_valid_i = vld;
    req_value_i = {v1, v0};
    g = 2'b00;
    if (!m_pend) begin
      if (m_rr == 1'b0) begin
        if (vld[0]) g = 2'b01;
        else if (vld[1]) g = 2'b10;
      end else begin
        if (vld[1]) g = 2'b10;
        else if (vld[0]) g = 2'b01;
      end
    end
    q      = en & rt;
    w      = q && (m_cnt == m_cur);
    n_cur  = m_cur;
    n_cnt  = m_cnt;
    n_sh   = m_shadow;
    n_pend = m_pend;
    n_rr   = m_rr;
    n_tick = w && !clr;
    ap     = m_pend && (!en || clr || w);
    if (ap) begin
      n_cur  = m_shadow;
      n_cnt  = 8'd0;
      n_pend = 1'b0;
    end else if (clr || w) begin
      n_cnt = 8'd0;
    end else if (q) begin
      n_cnt = m_cnt + 8'd1;
    end
    if (g != 2'b00) begin
      n_sh   = g[0] ? v0 : v1;
      n_rr   = g[0] ? 1'b1 : 1'b0;
      n_pend = 1'b1;
    end
    if (rst) begin
      n_cur = 8'd0; n_cnt = 8'd0; n_sh = 8'd0; n_tick = 1'b0; n_pend = 1'b0; n_rr = 1'b0;
    end
    exp_q.push_back({n_cur, n_cnt, n_tick, n_pend, g});
    #1;
    last_rdy = req_ready_o;
    @(posedge clk_i);
    #1;
    obs_q.push_back({cur_value_o, count_o, tick_o, pending_o, last_rdy});
    m_cur = n_cur; m_cnt = n_cnt; m_shadow = n_sh; m_tick = n_tick; m_pend = n_pend;
    m_rr = n_rr;
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    drive(1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    compared++;
    if ({cur_value_o, count_o, tick_o, pending_o, req_ready_o} !== 20'd0) begin
      mismatched++;
      $display("FAIL reset_values: observed %h required 00000",
               {cur_value_o, count_o, tick_o, pending_o, req_ready_o});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL reset_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_n0_n3;
    int          ticks;
    logic [31:0] cnt_seq;
    drive(0, 1, 0, 1, 2'b01, 8'd0, 8'd0);
    drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
      ticks += int'(tick_o);
    end
    compared++;
    if (ticks !== 8) begin
      mismatched++;
      $display("FAIL n0_ticks: observed %0d required 8", ticks);
    end
    drive(0, 1, 0, 1, 2'b01, 8'd3, 8'd0);
    drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    compared++;
    if ({cur_value_o, count_o} !== {8'd3, 8'd0}) begin
      mismatched++;
      $display("FAIL n3_apply: observed cur=%0d cnt=%0d required cur=3 cnt=0",
               cur_value_o, count_o);
    end
    ticks   = 0;
    cnt_seq = 32'd0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
      ticks += int'(tick_o);
      if (i < 4) cnt_seq = {cnt_seq[23:0], count_o};
    end
    compared++;
    if (ticks !== 4) begin
      mismatched++;
      $display("FAIL n3_ticks: observed %0d required 4", ticks);
    end
    compared++;
    if (cnt_seq !== 32'h01020300) begin
      mismatched++;
      $display("FAIL n3_count_seq: observed %h required 01020300", cnt_seq);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL n0_n3_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_round_robin;
    drive(1, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    drive(0, 0, 0, 0, 2'b11, 8'd5, 8'd9);
    compared++;
    if (last_rdy !== 2'b01) begin
      mismatched++;
      $display("FAIL rr_first_grant: observed %b required 01", last_rdy);
    end
    drive(0, 0, 0, 0, 2'b10, 8'd5, 8'd9);
    compared++;
    if ({last_rdy, cur_value_o} !== {2'b00, 8'd5}) begin
      mismatched++;
      $display("FAIL rr_apply5: observed rdy=%b cur=%0d required rdy=00 cur=5",
               last_rdy, cur_value_o);
    end
    drive(0, 0, 0, 0, 2'b10, 8'd5, 8'd9);
    compared++;
    if (last_rdy !== 2'b10) begin
      mismatched++;
      $display("FAIL rr_second_grant: observed %b required 10", last_rdy);
    end
    drive(0, 0, 0, 0, 2'b00, 8'd5, 8'd9);
    compared++;
    if (cur_value_o !== 8'd9) begin
      mismatched++;
      $display("FAIL rr_apply9: observed %0d required 9", cur_value_o);
    end
    drive(0, 0, 0, 0, 2'b11, 8'd5, 8'd9);
    compared++;
    if (last_rdy !== 2'b01) begin
      mismatched++;
      $display("FAIL rr_wraparound: observed %b required 01", last_rdy);
    end
    drive(0, 0, 0, 0, 2'b00, 8'd5, 8'd9);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL rr_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_wrap_apply;
    logic pend_ok;
    logic [2:0] tseq;
    drive(0, 0, 0, 0, 2'b01, 8'd7, 8'd0);
    drive(0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    compared++;
    if ({cur_value_o, count_o} !== {8'd7, 8'd3}) begin
      mismatched++;
      $display("FAIL wa_setup: observed cur=%0d cnt=%0d required cur=7 cnt=3",
               cur_value_o, count_o);
    end
    drive(0, 1, 0, 1, 2'b01, 8'd2, 8'd0);
    pend_ok = pending_o;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
      pend_ok = pend_ok & pending_o & ~tick_o & (cur_value_o == 8'd7);
    end
    compared++;
    if (pend_ok !== 1'b1) begin
      mismatched++;
      $display("FAIL wa_hold_pending: observed %b required 1", pend_ok);
    end
    drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    compared++;
    if ({cur_value_o, count_o, tick_o, pending_o} !== {8'd2, 8'd0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL wa_wrap_apply: observed cur=%0d cnt=%0d tick=%b pend=%b required 2 0 1 0",
               cur_value_o, count_o, tick_o, pending_o);
    end
    tseq = 3'b000;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
      tseq = {tseq[1:0], tick_o};
    end
    compared++;
    if (tseq !== 3'b001) begin
      mismatched++;
      $display("FAIL wa_new_period: observed %b required 001", tseq);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL wa_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_disabled_apply;
    drive(0, 0, 0, 1, 2'b01, 8'd6, 8'd0);
    compared++;
    if ({pending_o, cur_value_o} !== {1'b1, 8'd2}) begin
      mismatched++;
      $display("FAIL dis_accept: observed pend=%b cur=%0d required pend=1 cur=2",
               pending_o, cur_value_o);
    end
    drive(0, 0, 0, 1, 2'b00, 8'd0, 8'd0);
    compared++;
    if ({cur_value_o, count_o, tick_o, pending_o} !== {8'd6, 8'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL dis_apply: observed cur=%0d cnt=%0d tick=%b pend=%b required 6 0 0 0",
               cur_value_o, count_o, tick_o, pending_o);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL dis_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_clear_apply;
    drive(0, 0, 0, 0, 2'b01, 8'd10, 8'd0);
    drive(0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    drive(0, 1, 0, 1, 2'b01, 8'd1, 8'd0);
    drive(0, 1, 0, 0, 2'b01, 8'd8, 8'd0);
    compared++;
    if ({last_rdy, count_o, pending_o} !== {2'b00, 8'd4, 1'b1}) begin
      mismatched++;
      $display("FAIL clr_stall: observed rdy=%b cnt=%0d pend=%b required 00 4 1",
               last_rdy, count_o, pending_o);
    end
    drive(0, 1, 1, 1, 2'b01, 8'd8, 8'd0);
    compared++;
    if ({last_rdy, cur_value_o, count_o, tick_o, pending_o} !==
        {2'b00, 8'd1, 8'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL clr_apply: observed rdy=%b cur=%0d cnt=%0d tick=%b pend=%b req 00 1 0 0 0",
               last_rdy, cur_value_o, count_o, tick_o, pending_o);
    end
    drive(0, 1, 0, 0, 2'b00, 8'd0, 8'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL clr_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  task automatic test_reset_pending;
    logic idle_ok;
    drive(0, 0, 0, 0, 2'b01, 8'd9, 8'd0);
    drive(0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    drive(0, 1, 0, 1, 2'b01, 8'd3, 8'd0);
    compared++;
    if ({count_o, pending_o} !== {8'd6, 1'b1}) begin
      mismatched++;
      $display("FAIL rstp_setup: observed cnt=%0d pend=%b required 6 1", count_o, pending_o);
    end
    drive(1, 1, 0, 1, 2'b00, 8'd0, 8'd0);
    compared++;
    if ({cur_value_o, count_o, tick_o, pending_o} !== 18'd0) begin
      mismatched++;
      $display("FAIL rstp_reset: observed cur=%0d cnt=%0d tick=%b pend=%b required 0 0 0 0",
               cur_value_o, count_o, tick_o, pending_o);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
      idle_ok = idle_ok & (cur_value_o == 8'd0) & ~pending_o;
    end
    compared++;
    if (idle_ok !== 1'b1) begin
      mismatched++;
      $display("FAIL rstp_discarded: observed %b required 1", idle_ok);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL rstp_cycle: observed {cur,cnt,tick,pend,rdy}=%h required %h", o, e);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; ref_tick_i = 1'b0;
    req_valid_i = 2'b00; req_value_i = 16'd0;
    test_reset();
    test_n0_n3();
    test_round_robin();
    test_wrap_apply();
    test_disabled_apply();
    test_clear_apply();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
